padctrl_cfg_host: RTL and testbench
===================================

Name: padctrl_cfg_host

Overview:
- TL-UL initiator that programs the padctrl register block from a parallel attribute image.
- On start, it writes the MIO pad attribute words and the DIO pad attribute word to padctrl.
- It can optionally read every word back and compare it, then optionally clears REGEN to lock the configuration.
- Sits beside the boot/ROM controller and drives a host port on the peripheral crossbar toward padctrl.

Parameters:
- BaseAddr, 32'h4006_0000, padctrl base address.
- SourceId, 8'h00, a_source value on every request.
- NMioPads, 16, MIO pad count (must match the padctrl register package).
- NDioPads, 4, DIO pad count.
- AttrDw, 8, attribute bits per pad; NMioPads*AttrDw and NDioPads*AttrDw must be multiples of 32.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  one-cycle pulse; begins a sequence; ignored unless in IDLE/DONE/ERROR
- verify_i  in  1  sampled at start; enables the read-back compare phase
- lock_i  in  1  sampled at start; enables the final REGEN=0 write
- mio_attr_i  in  NMioPads*AttrDw  MIO image; captured at start
- dio_attr_i  in  NDioPads*AttrDw  DIO image; captured at start
- tl_o  out  102  TL-UL h2d packed struct {a_valid,a_opcode[3],a_param[3],a_size[2],a_source[8],a_address[32],a_mask[4],a_data[32],a_user[16],d_ready}
- tl_i  in  68  TL-UL d2h packed struct {d_valid,d_opcode[3],d_param[3],d_size[2],d_source[8],d_sink,d_data[32],d_user[16],d_error,a_ready}
- busy_o  out  1  sequence in progress
- done_o  out  1  level; sequence completed cleanly
- err_o  out  1  level; sequence aborted
- err_code_o  out  2  1=d_error, 2=readback mismatch, 3=unexpected d_opcode/d_source
- err_idx_o  out  3  word index at the failure

Behaviour:
- Reset values: tl_o all zero; busy_o, done_o, err_o, err_code_o and err_idx_o all 0; FSM in IDLE.
- Word map:
  - W = NMioPads*AttrDw/32 MIO words (4 by default), at BaseAddr+0x4+4*k with data mio[32k+:32].
  - Then NDioPads*AttrDw/32 DIO words at the following offsets (0x14 by default).
  - REGEN is at BaseAddr+0x0.
- Request fields, all requests:
  - a_size=2, a_mask=4'hF, a_param=0, a_user=0, a_source=SourceId.
  - PutFullData opcode=0; Get opcode=4 with a_data=0.
- FSM states: IDLE, WR_REQ, WR_RSP, RD_REQ, RD_RSP, LK_REQ, LK_RSP, DONE, ERROR.
- start_i in IDLE/DONE/ERROR:
  - Capture the images, verify_i and lock_i; clear done/err; set idx=0; go to WR_REQ.
- Any *_REQ state:
  - Drive a_valid=1 with stable fields until a cycle where a_ready=1.
  - On that cycle go to the matching *_RSP state.
- Any *_RSP state:
  - d_ready=1; d_ready=0 in all other states.
  - A d_valid arriving in a non-RSP state is not accepted.
  - Exactly one transaction is outstanding at a time.
- WR_RSP response checks:
  - d_error -> ERROR, code 1.
  - d_opcode!=AccessAck(0) or d_source!=SourceId -> ERROR, code 3.
  - Otherwise: if the last word -> RD_REQ (idx=0) when verify, else LK_REQ when lock, else DONE; if not the last word -> idx+1, WR_REQ.
- RD_RSP response checks:
  - Expect AccessAckData(1).
  - d_data mismatch with the captured word -> ERROR, code 2, err_idx_o=idx.
  - After the last word -> LK_REQ when lock, else DONE.
- LK_REQ/LK_RSP:
  - Write 32'h0 to REGEN; a clean response -> DONE.
- DONE/ERROR hold their flags until the next start_i. busy_o=1 in all REQ/RSP states.
- Edge conditions:
  - a_ready and d_valid in the same cycle as the request handshake: d_valid is not accepted that cycle; the response is taken in the RSP state.
  - start_i while busy is ignored.
  - Reset mid-transaction drops a_valid immediately; a stale response after reset is not accepted because FSM=IDLE keeps d_ready=0.

Decomposition:
- Shared package (existing tlul_pkg): tl_h2d_t/tl_d2h_t structs and the opcode enum (PutFullData, Get, AccessAck, AccessAckData).
- padctrl_reg_pkg: NMioPads, NDioPads, AttrDw and register offsets.
- One sub-module, padctrl_cfg_host_req: a single-outstanding TL-UL request/response channel with start/addr/wdata/we in and rvalid/rdata/err out. The FSM above is the sequencer on top of it.

Test Plan:
- a_ready=1 with an ideal 1-cycle responder, mio=128'h0123..CDEF, dio=32'hA5A5_5A5A, verify=0, lock=0 -> 5 PutFullData to 0x4..0x14 in order, done_o=1, tl_o=0 afterward.
- Responder holds a_ready=0 for 3 cycles on word 2 -> a_address/a_data stable throughout, exactly one request accepted.
- verify=1 with a responder that corrupts the read of word 3 -> err_o=1, err_code_o=2, err_idx_o=3, no lock write.
- d_error=1 on the DIO write -> ERROR code 1, err_idx_o=4; then start_i -> err cleared, sequence reruns cleanly.
- lock=1, verify=1 with a clean responder -> 5 writes, 5 reads, one write of 0 to 0x0, then done_o=1.
- Assert rst_ni during WR_REQ -> a_valid=0 at once, busy_o=0; a late d_valid is not accepted (d_ready=0).

Source files
------------

// File: rtl/padctrl_cfg_host_pkg.sv
// padctrl_cfg_host_pkg: TL-UL types, padctrl register map and sequencer states
package padctrl_cfg_host_pkg;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic [15:0] a_user;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic [15:0] d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

    typedef enum logic [2:0] {PutFullData = 3'd0, Get = 3'd4} tl_a_op_e;
    typedef enum logic [2:0] {AccessAck = 3'd0, AccessAckData = 3'd1} tl_d_op_e;

    localparam int DefNMioPads = 16;
    localparam int DefNDioPads = 4;
    localparam int DefAttrDw   = 8;

    localparam logic [31:0] RegenOffset   = 32'h0;
    localparam logic [31:0] MioAttrOffset = 32'h4;

    localparam logic [1:0] ErrDError   = 2'd1;
    localparam logic [1:0] ErrMismatch = 2'd2;
    localparam logic [1:0] ErrProto    = 2'd3;

    typedef enum logic [3:0] {
        IDLE, WR_REQ, WR_RSP, RD_REQ, RD_RSP, LK_REQ, LK_RSP, DONE, ERROR
    } state_e;

endpackage

// File: rtl/padctrl_cfg_host_req.sv
// padctrl_cfg_host_req: single-outstanding TL-UL request/response channel
// req_i holds a_valid, rsp_i holds d_ready; acc_o/rvalid_o flag the A/D handshakes,
// derr_o/bad_o/rdata_o describe the response taken on rvalid_o.
module padctrl_cfg_host_req
    import padctrl_cfg_host_pkg::*;
#(
    parameter logic [7:0] SourceId = 8'h00
) (
    input  logic        req_i,
    input  logic        rsp_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  tl_d2h_t     tl_i,
    output tl_h2d_t     tl_o,
    output logic        acc_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        derr_o,
    output logic        bad_o
);
    logic unused_tl;

    always_comb begin
        tl_o = '0;
        if (req_i) begin
            tl_o.a_valid   = 1'b1;
            tl_o.a_opcode  = we_i ? PutFullData : Get;
            tl_o.a_size    = 2'd2;
            tl_o.a_source  = SourceId;
            tl_o.a_address = addr_i;
            tl_o.a_mask    = 4'hF;
            tl_o.a_data    = we_i ? wdata_i : 32'h0;
        end
        tl_o.d_ready = rsp_i;
    end

    assign acc_o    = req_i && tl_i.a_ready;
    assign rvalid_o = rsp_i && tl_i.d_valid;
    assign rdata_o  = tl_i.d_data;
    assign derr_o   = tl_i.d_error;
    assign bad_o    = tl_i.d_opcode != (we_i ? AccessAck : AccessAckData) || tl_i.d_source != SourceId;

    assign unused_tl = ^{tl_i.d_param, tl_i.d_size, tl_i.d_sink, tl_i.d_user};

endmodule

// File: rtl/padctrl_cfg_host.sv
// padctrl_cfg_host: programs padctrl MIO/DIO attributes over TL-UL, optional verify and REGEN lock
// start_i/verify_i/lock_i and the attribute images are sampled on start; tl_o/tl_i is the
// crossbar host port; busy_o/done_o/err_o with err_code_o/err_idx_o report progress and outcome.
module padctrl_cfg_host
    import padctrl_cfg_host_pkg::*;
#(
    parameter logic [31:0] BaseAddr = 32'h4006_0000,
    parameter logic [7:0]  SourceId = 8'h00,
    parameter int          NMioPads = DefNMioPads,
    parameter int          NDioPads = DefNDioPads,
    parameter int          AttrDw   = DefAttrDw
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       start_i,
    input  logic                       verify_i,
    input  logic                       lock_i,
    input  logic [NMioPads*AttrDw-1:0] mio_attr_i,
    input  logic [NDioPads*AttrDw-1:0] dio_attr_i,
    output tl_h2d_t                    tl_o,
    input  tl_d2h_t                    tl_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o,
    output logic [1:0]                 err_code_o,
    output logic [2:0]                 err_idx_o
);
    localparam int         ImgW    = (NMioPads + NDioPads) * AttrDw;
    localparam int         NWords  = ImgW / 32;
    localparam logic [2:0] LastIdx = 3'(NWords - 1);

    state_e          state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic            verify_q, verify_d;
    logic            lock_q, lock_d;
    logic [ImgW-1:0] img_q, img_d;
    logic [1:0]      code_q, code_d;
    logic [2:0]      eidx_q, eidx_d;
    logic            req, rsp, we, acc, rvalid, derr, bad;
    logic [31:0]     addr, wdata, rdata;

    assign req   = state_q inside {WR_REQ, RD_REQ, LK_REQ};
    assign rsp   = state_q inside {WR_RSP, RD_RSP, LK_RSP};
    assign we    = !(state_q inside {RD_REQ, RD_RSP});
    assign addr  = state_q == LK_REQ ? BaseAddr + RegenOffset
                                     : BaseAddr + MioAttrOffset + {27'd0, idx_q, 2'd0};
    // Outside LK_REQ this is the captured word at idx, which is also the read-back reference.
    assign wdata = state_q == LK_REQ ? 32'h0 : img_q[{idx_q, 5'd0} +: 32];

    padctrl_cfg_host_req #(.SourceId(SourceId)) u_req (
        .req_i    (req),
        .rsp_i    (rsp),
        .we_i     (we),
        .addr_i   (addr),
        .wdata_i  (wdata),
        .tl_i     (tl_i),
        .tl_o     (tl_o),
        .acc_o    (acc),
        .rvalid_o (rvalid),
        .rdata_o  (rdata),
        .derr_o   (derr),
        .bad_o    (bad)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        verify_d = verify_q;
        lock_d   = lock_q;
        img_d    = img_q;
        code_d   = code_q;
        eidx_d   = eidx_q;
        case (state_q)
            IDLE, DONE, ERROR: if (start_i) begin
                state_d  = WR_REQ;
                idx_d    = '0;
                verify_d = verify_i;
                lock_d   = lock_i;
                img_d    = {dio_attr_i, mio_attr_i};
                code_d   = '0;
                eidx_d   = '0;
            end
            WR_REQ: if (acc) state_d = WR_RSP;
            RD_REQ: if (acc) state_d = RD_RSP;
            LK_REQ: if (acc) state_d = LK_RSP;
            WR_RSP, RD_RSP, LK_RSP: if (rvalid) begin
                if (derr || bad || (state_q == RD_RSP && rdata != wdata)) begin
                    state_d = ERROR;
                    code_d  = derr ? ErrDError : bad ? ErrProto : ErrMismatch;
                    eidx_d  = idx_q;
                end else if (state_q == LK_RSP) begin
                    state_d = DONE;
                end else if (idx_q != LastIdx) begin
                    idx_d   = idx_q + 3'd1;
                    state_d = state_q == WR_RSP ? WR_REQ : RD_REQ;
                end else begin
                    idx_d   = '0;
                    state_d = state_q == WR_RSP && verify_q ? RD_REQ : lock_q ? LK_REQ : DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            verify_q <= 1'b0;
            lock_q   <= 1'b0;
            img_q    <= '0;
            code_q   <= '0;
            eidx_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            verify_q <= verify_d;
            lock_q   <= lock_d;
            img_q    <= img_d;
            code_q   <= code_d;
            eidx_q   <= eidx_d;
        end
    end

    assign busy_o     = req || rsp;
    assign done_o     = state_q == DONE;
    assign err_o      = state_q == ERROR;
    assign err_code_o = code_q;
    assign err_idx_o  = eidx_q;

endmodule

// File: tb/tb_padctrl_cfg_host.sv
// tb_padctrl_cfg_host: randomized sequences against a TL-UL memory responder and a transaction-list model
module tb_padctrl_cfg_host;
    import padctrl_cfg_host_pkg::*;

    localparam logic [31:0] Base = 32'h4006_0000;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         start_i = 1'b0;
    logic         verify_i = 1'b0;
    logic         lock_i = 1'b0;
    logic [127:0] mio_attr_i = '0;
    logic [31:0]  dio_attr_i = '0;
    tl_h2d_t      tl_o;
    tl_d2h_t      tl_i = '0;
    logic         busy_o, done_o, err_o;
    logic [1:0]   err_code_o;
    logic [2:0]   err_idx_o;

    int total = 0;
    int bad = 0;

    logic [31:0] stall_addr = '1, derr_addr = '1, src_addr = '1, corrupt_addr = '1;
    int          stall_left = 0;
    bit          stall_seen = 0;
    logic [31:0] ref_a, ref_d;
    bit          have_rsp = 0;
    tl_d2h_t     rsp = '0;
    logic [31:0] mem [logic [31:0]];
    txn_t        log_q[$], exp_q[$];
    bit          exp_done;
    logic [1:0]  exp_code;
    logic [2:0]  exp_idx;

    padctrl_cfg_host dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (start_i),
        .verify_i   (verify_i),
        .lock_i     (lock_i),
        .mio_attr_i (mio_attr_i),
        .dio_attr_i (dio_attr_i),
        .tl_o       (tl_o),
        .tl_i       (tl_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .err_code_o (err_code_o),
        .err_idx_o  (err_idx_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Expected bus traffic and outcome: write every word in order, optionally read them all
    // back, optionally clear REGEN; the first faulted response ends the sequence.
    task automatic model(input logic [127:0] mio, input logic [31:0] dio, input bit v, input bit l,
                         input int dw, input int sw, input int cr);
        logic [31:0] w [5];
        exp_q.delete();
        for (int k = 0; k < 4; k++) w[k] = mio[32*k +: 32];
        w[4] = dio;
        exp_done = 1;
        exp_code = 0;
        exp_idx  = 0;
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back('{3'd0, Base + 32'd4 + 32'(4*k), w[k]});
            if (k == dw || k == sw) begin
                exp_done = 0;
                exp_code = k == dw ? 2'd1 : 2'd3;
                exp_idx  = 3'(k);
                return;
            end
        end
        if (v) for (int k = 0; k < 5; k++) begin
            exp_q.push_back('{3'd4, Base + 32'd4 + 32'(4*k), 32'h0});
            if (k == cr) begin
                exp_done = 0;
                exp_code = 2'd2;
                exp_idx  = 3'(k);
                return;
            end
        end
        if (l) exp_q.push_back('{3'd0, Base, 32'h0});
    endtask

    initial begin : responder
        tl_h2d_t h;
        tl_d2h_t d;
        bit      rdy;
        forever begin
            @(negedge clk_i);
            h   = tl_o;
            rdy = !(h.a_valid && h.a_address == stall_addr && stall_left > 0);
            if (h.a_valid && stall_seen) begin
                chk("stable_addr", h.a_address, ref_a);
                chk("stable_data", h.a_data, ref_d);
            end
            if (!rdy) begin
                stall_left--;
                if (!stall_seen) begin
                    stall_seen = 1;
                    ref_a = h.a_address;
                    ref_d = h.a_data;
                end
            end
            d = have_rsp ? rsp : '0;
            d.a_ready = rdy;
            tl_i = d;
            if (have_rsp && h.d_ready) have_rsp = 0;
            if (h.a_valid && rdy) begin
                stall_seen = 0;
                chk("a_fields", {h.a_param, h.a_size, h.a_source, h.a_mask, h.a_user},
                    {3'd0, 2'd2, 8'h00, 4'hF, 16'h0});
                log_q.push_back('{h.a_opcode, h.a_address, h.a_data});
                rsp = '0;
                rsp.d_valid = 1'b1;
                if (h.a_opcode == 3'd0) begin
                    mem[h.a_address] = h.a_data;
                    rsp.d_opcode = 3'd0;
                    rsp.d_error  = h.a_address == derr_addr;
                    rsp.d_source = h.a_address == src_addr ? 8'h5A : 8'h00;
                end else begin
                    rsp.d_opcode = 3'd1;
                    rsp.d_data   = mem[h.a_address] ^ (h.a_address == corrupt_addr ? 32'h0000_0100 : 32'h0);
                end
                have_rsp = 1;
            end
        end
    end

    task automatic run(input logic [127:0] mio, input logic [31:0] dio, input bit v, input bit l,
                       input int dw, input int sw, input int cr, input int restart_at);
        bit fin;
        derr_addr    = dw >= 0 ? Base + 32'd4 + 32'(4*dw) : '1;
        src_addr     = sw >= 0 ? Base + 32'd4 + 32'(4*sw) : '1;
        corrupt_addr = cr >= 0 ? Base + 32'd4 + 32'(4*cr) : '1;
        model(mio, dio, v, l, dw, sw, cr);
        log_q.delete();
        @(negedge clk_i);
        mio_attr_i = mio;
        dio_attr_i = dio;
        verify_i   = v;
        lock_i     = l;
        start_i    = 1;
        @(negedge clk_i);
        start_i    = 0;
        mio_attr_i = ~mio;
        dio_attr_i = ~dio;
        verify_i   = ~v;
        lock_i     = ~l;
        chk("busy_after_start", busy_o, 1);
        chk("flags_cleared", {done_o, err_o, err_code_o, err_idx_o}, 0);
        fin = 0;
        for (int c = 0; c < 400; c++) begin
            if (done_o || err_o) begin
                fin = 1;
                break;
            end
            start_i = c == restart_at;
            @(negedge clk_i);
        end
        start_i = 0;
        chk("finished", fin, 1);
        chk("txn_count", log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) if (i < log_q.size()) begin
            chk("txn_op", log_q[i].op, exp_q[i].op);
            chk("txn_addr", log_q[i].addr, exp_q[i].addr);
            chk("txn_data", log_q[i].data, exp_q[i].data);
        end
        chk("done", done_o, exp_done);
        chk("err", err_o, !exp_done);
        chk("err_code", err_code_o, exp_code);
        chk("err_idx", err_idx_o, exp_idx);
        chk("busy_end", busy_o, 0);
        chk("tl_idle", tl_o, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        #1;
        chk("rst_tl", tl_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_code", err_code_o, 0);
        chk("rst_idx", err_idx_o, 0);
        rst_ni = 1;

        run(128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF, 32'hA5A5_5A5A, 0, 0, -1, -1, -1, -1);

        stall_addr = Base + 32'h0C;
        stall_left = 3;
        run(rnd128(), $urandom, 0, 0, -1, -1, -1, -1);
        chk("stall_consumed", stall_left, 0);

        run(rnd128(), $urandom, 1, 1, -1, -1, 3, -1);
        run(rnd128(), $urandom, 0, 0, 4, -1, -1, -1);
        run(rnd128(), $urandom, 0, 0, -1, -1, -1, -1);
        run(rnd128(), $urandom, 1, 1, -1, -1, -1, -1);
        run(rnd128(), $urandom, 1, 0, -1, -1, -1, 3);
        run(rnd128(), $urandom, 0, 1, -1, 2, -1, -1);

        for (int r = 0; r < 6; r++) begin
            int f, k;
            f = int'($urandom_range(0, 3));
            k = int'($urandom_range(0, 4));
            run(rnd128(), $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                f == 1 ? k : -1, f == 2 ? k : -1, f == 3 ? k : -1, -1);
        end

        stall_addr = Base + 32'h4;
        stall_left = 1000;
        @(negedge clk_i);
        mio_attr_i = rnd128();
        start_i = 1;
        @(negedge clk_i);
        start_i = 0;
        repeat (3) @(negedge clk_i);
        #2 rst_ni = 0;
        #1;
        chk("rst_mid_avalid", tl_o.a_valid, 0);
        chk("rst_mid_busy", busy_o, 0);
        chk("rst_mid_tl", tl_o, 0);
        stall_left = 0;
        stall_seen = 0;
        rsp = '0;
        rsp.d_valid = 1'b1;
        have_rsp = 1;
        @(negedge clk_i);
        #2 rst_ni = 1;
        repeat (3) begin
            @(negedge clk_i);
            #1;
            chk("stale_dready", tl_o.d_ready, 0);
            chk("stale_state", {busy_o, done_o, err_o}, 0);
        end
        have_rsp = 0;
        @(negedge clk_i);

        run(rnd128(), $urandom, 1, 1, -1, -1, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
